// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the LC-3b pipeline.
// Sits between EX/MEM and MEM/WB. It issues data-memory transactions for
// LDR/STR/LDB/STB/LDI/STI and stalls upstream while one is outstanding.
// It forms the writeback value and pulses wb_load once per instruction.
// Optional feature: define MEM_STAGE_INDIRECT_EN to give LDI/STI their
// second (indirect) access. Without it, LDI acts as LDR and STI acts as STR.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [3:0]  opcode_in,
    input  logic [2:0]  dest_in,
    input  logic [15:0] alu_out_in,
    input  logic [15:0] sr_data_in,
    input  logic [15:0] pc_in,
    input  logic        load_regfile_in,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        stall_out,
    output logic        wb_load,
    output logic [2:0]  dest_out,
    output logic [15:0] regfilemux_out,
    output logic        load_regfile_out
);

    // LC-3b opcodes this stage cares about (JSRR shares the JSR opcode)
    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_STB  = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_TRAP = 4'b1111;

`ifdef MEM_STAGE_INDIRECT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC1   = 2'd1,
        ST_ACC2   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC1   = 2'd1,
        ST_RESULT = 2'd3
    } state_t;
`endif

    // True for every opcode that touches data memory
    function automatic logic is_mem_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_LDR, OP_STR, OP_LDB, OP_STB, OP_LDI, OP_STI: r = 1'b1;
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

    // Direction of the first access: STI reads its pointer first only when
    // the indirect access exists; otherwise it is a plain word store.
    function automatic logic first_is_read(input logic [3:0] op);
        logic r;
        case (op)
            OP_LDR, OP_LDB, OP_LDI: r = 1'b1;
`ifdef MEM_STAGE_INDIRECT_EN
            OP_STI:                 r = 1'b1;
`else
            OP_STI:                 r = 1'b0;
`endif
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic first_is_write(input logic [3:0] op);
        logic r;
        case (op)
            OP_STR, OP_STB: r = 1'b1;
`ifdef MEM_STAGE_INDIRECT_EN
            OP_STI:         r = 1'b0;
`else
            OP_STI:         r = 1'b1;
`endif
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

    // Byte stores select the lane from address bit 0; all else is a word
    function automatic logic [1:0] first_be(input logic [3:0] op, input logic addr0);
        logic [1:0] r;
        if (op == OP_STB) begin
            r = addr0 ? 2'b10 : 2'b01;
        end else begin
            r = 2'b11;
        end
        return r;
    endfunction

    // Byte stores replicate the low byte onto both lanes
    function automatic logic [15:0] first_wdata(input logic [3:0] op, input logic [15:0] sr);
        logic [15:0] r;
        if (op == OP_STB) begin
            r = {sr[7:0], sr[7:0]};
        end else begin
            r = sr;
        end
        return r;
    endfunction

    state_t      state_q;
    logic [3:0]  op_q;
    logic [2:0]  dest_q;
    logic [15:0] alu_q;
    logic        ldrf_q;
    logic        dmem_read_q;
    logic        dmem_write_q;
    logic [15:0] dmem_address_q;
    logic [15:0] dmem_wdata_q;
    logic [1:0]  dmem_be_q;
    logic        wb_load_q;
    logic [2:0]  dest_out_q;
    logic [15:0] regfilemux_q;
    logic        ldrf_out_q;

    logic        in_mem_s;
    logic        acc_busy_s;
    logic [15:0] pt_value_s;
    logic [15:0] mem_value_d;
`ifdef MEM_STAGE_INDIRECT_EN
    logic        go_indirect_s;
`endif

    // Decode the incoming opcode and select the pass-through writeback value
    always_comb begin
        in_mem_s   = is_mem_op(opcode_in);
        pt_value_s = alu_out_in;
        case (opcode_in)
            OP_JSR, OP_TRAP: pt_value_s = pc_in;
            default:         pt_value_s = alu_out_in;
        endcase
    end

    // Writeback value captured when the final memory response arrives
    always_comb begin
        mem_value_d = alu_q;
        case (op_q)
            OP_LDR, OP_LDI: mem_value_d = dmem_rdata;
            OP_LDB: begin
                if (dmem_address_q[0]) begin
                    mem_value_d = {8'h00, dmem_rdata[15:8]};
                end else begin
                    mem_value_d = {8'h00, dmem_rdata[7:0]};
                end
            end
            default: mem_value_d = alu_q;
        endcase
    end

`ifdef MEM_STAGE_INDIRECT_EN
    // Indirect ops take a second access after the pointer read
    always_comb begin
        if ((op_q == OP_LDI) || (op_q == OP_STI)) begin
            go_indirect_s = 1'b1;
        end else begin
            go_indirect_s = 1'b0;
        end
    end

    assign acc_busy_s = (state_q == ST_ACC1) || (state_q == ST_ACC2);
`else
    assign acc_busy_s = (state_q == ST_ACC1);
`endif

    // Hold upstream while a memory op is being accepted or is in flight
    assign stall_out = ((state_q == ST_IDLE) && in_valid && in_mem_s) || acc_busy_s;

    // Stage FSM: request registers, latched instruction fields and results
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_q           <= 4'h0;
            dest_q         <= 3'h0;
            alu_q          <= 16'h0000;
            ldrf_q         <= 1'b0;
            dmem_read_q    <= 1'b0;
            dmem_write_q   <= 1'b0;
            dmem_address_q <= 16'h0000;
            dmem_wdata_q   <= 16'h0000;
            dmem_be_q      <= 2'b00;
            wb_load_q      <= 1'b0;
            dest_out_q     <= 3'h0;
            regfilemux_q   <= 16'h0000;
            ldrf_out_q     <= 1'b0;
        end else begin
            wb_load_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_mem_s) begin
                        op_q           <= opcode_in;
                        dest_q         <= dest_in;
                        alu_q          <= alu_out_in;
                        ldrf_q         <= load_regfile_in;
                        dmem_address_q <= alu_out_in;
                        dmem_wdata_q   <= first_wdata(opcode_in, sr_data_in);
                        dmem_be_q      <= first_be(opcode_in, alu_out_in[0]);
                        dmem_read_q    <= first_is_read(opcode_in);
                        dmem_write_q   <= first_is_write(opcode_in);
                        state_q        <= ST_ACC1;
                    end else if (in_valid) begin
                        dest_out_q   <= dest_in;
                        regfilemux_q <= pt_value_s;
                        ldrf_out_q   <= load_regfile_in;
                        wb_load_q    <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACC1: begin
`ifdef MEM_STAGE_INDIRECT_EN
                    if (dmem_resp && go_indirect_s) begin
                        // Pointer returned: retarget the request at it
                        dmem_address_q <= dmem_rdata;
                        dmem_be_q      <= 2'b11;
                        dmem_read_q    <= (op_q == OP_LDI);
                        dmem_write_q   <= (op_q == OP_STI);
                        state_q        <= ST_ACC2;
                    end else if (dmem_resp) begin
`else
                    if (dmem_resp) begin
`endif
                        dmem_read_q  <= 1'b0;
                        dmem_write_q <= 1'b0;
                        dest_out_q   <= dest_q;
                        regfilemux_q <= mem_value_d;
                        ldrf_out_q   <= ldrf_q;
                        wb_load_q    <= 1'b1;
                        state_q      <= ST_RESULT;
                    end else begin
                        state_q <= ST_ACC1;
                    end
                end
`ifdef MEM_STAGE_INDIRECT_EN
                ST_ACC2: begin
                    if (dmem_resp) begin
                        dmem_read_q  <= 1'b0;
                        dmem_write_q <= 1'b0;
                        dest_out_q   <= dest_q;
                        regfilemux_q <= mem_value_d;
                        ldrf_out_q   <= ldrf_q;
                        wb_load_q    <= 1'b1;
                        state_q      <= ST_RESULT;
                    end else begin
                        state_q <= ST_ACC2;
                    end
                end
`endif
                ST_RESULT: begin
                    // The held upstream instruction is the one just retired
                    state_q <= ST_IDLE;
                end
                default: begin
                    dmem_read_q  <= 1'b0;
                    dmem_write_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign dmem_read        = dmem_read_q;
    assign dmem_write       = dmem_write_q;
    assign dmem_address     = dmem_address_q;
    assign dmem_wdata       = dmem_wdata_q;
    assign dmem_byte_enable = dmem_be_q;
    assign wb_load          = wb_load_q;
    assign dest_out         = dest_out_q;
    assign regfilemux_out   = regfilemux_q;
    assign load_regfile_out = ldrf_out_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vectors, scoreboard-checked writebacks.
module tb_mem_stage;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_TRAP = 4'b1111;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_STB  = 4'b0011;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  opcode_in = 4'h0;
    logic [2:0]  dest_in = 3'h0;
    logic [15:0] alu_out_in = 16'h0000;
    logic [15:0] sr_data_in = 16'h0000;
    logic [15:0] pc_in = 16'h0000;
    logic        load_regfile_in = 1'b0;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic        dmem_resp = 1'b0;
    logic [15:0] dmem_rdata = 16'h0000;
    logic        stall_out;
    logic        wb_load;
    logic [2:0]  dest_out;
    logic [15:0] regfilemux_out;
    logic        load_regfile_out;

    typedef struct packed {
        logic [2:0]  dest;
        logic [15:0] val;
        logic        ldrf;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    wb_exp_t mon_e;
    int checks = 0;
    int failures = 0;

    mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .opcode_in        (opcode_in),
        .dest_in          (dest_in),
        .alu_out_in       (alu_out_in),
        .sr_data_in       (sr_data_in),
        .pc_in            (pc_in),
        .load_regfile_in  (load_regfile_in),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .stall_out        (stall_out),
        .wb_load          (wb_load),
        .dest_out         (dest_out),
        .regfilemux_out   (regfilemux_out),
        .load_regfile_out (load_regfile_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic [2:0] d, input logic [15:0] v, input logic lr);
        wb_exp_t e;
        e.dest = d;
        e.val  = v;
        e.ldrf = lr;
        sb_q.push_back(e);
    endtask

    // Monitor: every wb_load must match the oldest expected writeback
    always @(negedge clk) begin
        if (!reset && (wb_load === 1'b1)) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected: actual dest=%0d val=0x%0h required=no writeback", dest_out, regfilemux_out);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wb_dest", 32'(dest_out), 32'(mon_e.dest));
                chk("wb_value", 32'(regfilemux_out), 32'(mon_e.val));
                chk("wb_ldrf", 32'(load_regfile_out), 32'(mon_e.ldrf));
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge
    task automatic issue_pt(input logic [3:0] op, input logic [2:0] d, input logic [15:0] alu,
                            input logic [15:0] pc, input logic lr, input logic [15:0] exp_val);
        in_valid = 1'b1; opcode_in = op; dest_in = d; alu_out_in = alu;
        pc_in = pc; load_regfile_in = lr; sr_data_in = 16'h0000;
        sb_push(d, exp_val, lr);
        @(negedge clk);
        chk("pt_stall", 32'(stall_out), 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_mem(input logic [3:0] op, input logic [2:0] d, input logic [15:0] alu,
                             input logic [15:0] sr, input logic lr, input bit push,
                             input logic [15:0] exp_val);
        in_valid = 1'b1; opcode_in = op; dest_in = d; alu_out_in = alu;
        sr_data_in = sr; load_regfile_in = lr; pc_in = 16'hFFFF;
        if (push) sb_push(d, exp_val, lr);
        @(negedge clk);
        chk("accept_stall", 32'(stall_out), 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic mem_access(input string tag, input bit is_wr, input logic [15:0] ea,
                              input logic [1:0] ebe, input bit chk_wd, input logic [15:0] ewd,
                              input int dly, input logic [15:0] rd);
        @(negedge clk);
        chk($sformatf("%s_read", tag), 32'(dmem_read), 32'(!is_wr));
        chk($sformatf("%s_write", tag), 32'(dmem_write), 32'(is_wr));
        chk($sformatf("%s_addr", tag), 32'(dmem_address), 32'(ea));
        chk($sformatf("%s_be", tag), 32'(dmem_byte_enable), 32'(ebe));
        if (chk_wd) chk($sformatf("%s_wdata", tag), 32'(dmem_wdata), 32'(ewd));
        chk($sformatf("%s_stall", tag), 32'(stall_out), 32'h1);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk($sformatf("%s_hold_req", tag), 32'(dmem_read | dmem_write), 32'h1);
            chk($sformatf("%s_hold_addr", tag), 32'(dmem_address), 32'(ea));
            chk($sformatf("%s_hold_stall", tag), 32'(stall_out), 32'h1);
        end
        dmem_resp = 1'b1;
        dmem_rdata = rd;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
    endtask

    // Result cycle: upstream is still presenting the op, which must not restart
    task automatic finish_mem(input string tag);
        @(negedge clk);
        chk($sformatf("%s_result_stall", tag), 32'(stall_out), 32'h0);
        chk($sformatf("%s_result_wb", tag), 32'(wb_load), 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_no_reaccept", tag), 32'(dmem_read | dmem_write), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_read", 32'(dmem_read), 32'h0);
        chk("rst_write", 32'(dmem_write), 32'h0);
        chk("rst_stall", 32'(stall_out), 32'h0);
        chk("rst_wb", 32'(wb_load), 32'h0);
        chk("rst_rfmux", 32'(regfilemux_out), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Pass-through ops, including back-to-back acceptance
        issue_pt(OP_ADD, 3'd3, 16'h1234, 16'h0000, 1'b1, 16'h1234);
        @(negedge clk);
        @(negedge clk);
        chk("idle_wb", 32'(wb_load), 32'h0);
        chk("idle_hold", 32'(regfilemux_out), 32'h1234);
        @(posedge clk); #1;
        issue_pt(OP_AND, 3'd1, 16'h00F0, 16'h0000, 1'b1, 16'h00F0);
        issue_pt(OP_JSR, 3'd7, 16'h9999, 16'h0456, 1'b1, 16'h0456);
        issue_pt(OP_TRAP, 3'd7, 16'h0000, 16'h0200, 1'b1, 16'h0200);
        @(posedge clk); #1;

        // LDR with a 3-cycle delayed response
        issue_mem(OP_LDR, 3'd2, 16'h2000, 16'h0000, 1'b1, 1'b1, 16'hBEEF);
        mem_access("ldr", 1'b0, 16'h2000, 2'b11, 1'b0, 16'h0000, 3, 16'hBEEF);
        finish_mem("ldr");

        // Byte stores: odd and even lanes
        issue_mem(OP_STB, 3'd0, 16'h3001, 16'h00A5, 1'b0, 1'b1, 16'h3001);
        mem_access("stb_odd", 1'b1, 16'h3001, 2'b10, 1'b1, 16'hA5A5, 0, 16'h0000);
        finish_mem("stb_odd");
        issue_mem(OP_STB, 3'd0, 16'h3000, 16'h12C3, 1'b0, 1'b1, 16'h3000);
        mem_access("stb_even", 1'b1, 16'h3000, 2'b01, 1'b1, 16'hC3C3, 1, 16'h0000);
        finish_mem("stb_even");

        // Byte loads: zero-extended high and low lanes
        issue_mem(OP_LDB, 3'd4, 16'h3001, 16'h0000, 1'b1, 1'b1, 16'h0080);
        mem_access("ldb_odd", 1'b0, 16'h3001, 2'b11, 1'b0, 16'h0000, 0, 16'h80FF);
        finish_mem("ldb_odd");
        issue_mem(OP_LDB, 3'd4, 16'h3000, 16'h0000, 1'b1, 1'b1, 16'h00FF);
        mem_access("ldb_even", 1'b0, 16'h3000, 2'b11, 1'b0, 16'h0000, 2, 16'h80FF);
        finish_mem("ldb_even");

        // Word store
        issue_mem(OP_STR, 3'd5, 16'h2100, 16'h1357, 1'b0, 1'b1, 16'h2100);
        mem_access("str", 1'b1, 16'h2100, 2'b11, 1'b1, 16'h1357, 1, 16'h0000);
        finish_mem("str");

`ifdef MEM_STAGE_INDIRECT_EN
        issue_mem(OP_LDI, 3'd6, 16'h4000, 16'h0000, 1'b1, 1'b1, 16'h7777);
        mem_access("ldi_ptr", 1'b0, 16'h4000, 2'b11, 1'b0, 16'h0000, 1, 16'h5000);
        mem_access("ldi_data", 1'b0, 16'h5000, 2'b11, 1'b0, 16'h0000, 1, 16'h7777);
        finish_mem("ldi");
        issue_mem(OP_STI, 3'd1, 16'h4000, 16'hCAFE, 1'b0, 1'b1, 16'h4000);
        mem_access("sti_ptr", 1'b0, 16'h4000, 2'b11, 1'b0, 16'h0000, 0, 16'h6000);
        mem_access("sti_data", 1'b1, 16'h6000, 2'b11, 1'b1, 16'hCAFE, 1, 16'h0000);
        finish_mem("sti");
`else
        issue_mem(OP_LDI, 3'd6, 16'h4000, 16'h0000, 1'b1, 1'b1, 16'h5000);
        mem_access("ldi_single", 1'b0, 16'h4000, 2'b11, 1'b0, 16'h0000, 1, 16'h5000);
        finish_mem("ldi");
        issue_mem(OP_STI, 3'd1, 16'h4000, 16'hCAFE, 1'b0, 1'b1, 16'h4000);
        mem_access("sti_single", 1'b1, 16'h4000, 2'b11, 1'b1, 16'hCAFE, 1, 16'h0000);
        finish_mem("sti");
`endif

        // Reset while the first access is outstanding
        issue_mem(OP_LDR, 3'd2, 16'h2222, 16'h0000, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        chk("pre_rst_read", 32'(dmem_read), 32'h1);
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_read", 32'(dmem_read), 32'h0);
        chk("mid_rst_write", 32'(dmem_write), 32'h0);
        chk("mid_rst_addr", 32'(dmem_address), 32'h0);
        chk("mid_rst_wdata", 32'(dmem_wdata), 32'h0);
        chk("mid_rst_be", 32'(dmem_byte_enable), 32'h0);
        chk("mid_rst_stall", 32'(stall_out), 32'h0);
        chk("mid_rst_wb", 32'(wb_load), 32'h0);
        chk("mid_rst_dest", 32'(dest_out), 32'h0);
        chk("mid_rst_rfmux", 32'(regfilemux_out), 32'h0);
        chk("mid_rst_ldrf", 32'(load_regfile_out), 32'h0);
        @(negedge clk);
        dmem_resp = 1'b1;
        dmem_rdata = 16'hDEAD;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        @(negedge clk);
        chk("late_resp_wb", 32'(wb_load), 32'h0);
        chk("late_resp_read", 32'(dmem_read), 32'h0);
        @(negedge clk);
        chk("late_resp_wb2", 32'(wb_load), 32'h0);
        @(posedge clk); #1;
        issue_pt(OP_ADD, 3'd3, 16'hABCD, 16'h0000, 1'b1, 16'hABCD);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the LC-3b pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It issues data-memory transactions for LDR/STR/LDB/STB/LDI/STI, stalls upstream while a transaction is outstanding, and forms the writeback value. It also produces the load strobe, `wb_load`, which the MEM/WB register uses as its load enable.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  — the single clock.
- `reset`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — EX/MEM holds a valid instruction.
- `opcode_in`  in  4  — `lc3b_opcode`.
- `dest_in`  in  3  — destination register.
- `alu_out_in`  in  16  — ALU result / effective address.
- `sr_data_in`  in  16  — store data.
- `pc_in`  in  16  — link value for JSR/JSRR/TRAP.
- `load_regfile_in`  in  1  — regfile write enable from decode.
- `dmem_read`, `dmem_write`  out  1 each.
- `dmem_address`  out  16.
- `dmem_wdata`  out  16.
- `dmem_byte_enable`  out  2.
- `dmem_resp`  in  1  — one-cycle completion pulse.
- `dmem_rdata`  in  16.
- `stall_out`  out  1  — upstream registers hold while high.
- `wb_load`  out  1  — one-cycle strobe; MEM/WB captures the outputs below on this strobe.
- `dest_out`  out  3.
- `regfilemux_out`  out  16.
- `load_regfile_out`  out  1.

## Operation
- **Memory ops**: LDR, STR, LDB, STB, LDI, STI. All other opcodes are pass-through.
- **FSM states**:
  - IDLE: accepts a new instruction.
  - ACC1: first memory access.
  - ACC2: second (indirect) access.
  - RESULT: one-cycle result presentation.
- **IDLE**:
  - `in_valid` with a pass-through op: latch result fields and stay in IDLE.
  - `in_valid` with a memory op: latch opcode, dest, address=`alu_out_in`, `sr_data_in`, `load_regfile_in`; go to ACC1.
- **ACC1**: request at the latched address.
  - Read for LDR/LDB/LDI/STI; write for STR/STB.
  - On `dmem_resp`: LDI/STI go to ACC2, with address ← `dmem_rdata`. All others go to RESULT.
- **ACC2**:
  - LDI reads at the pointer; STI writes `sr_data` at the pointer.
  - On `dmem_resp`: go to RESULT.
- **RESULT**: `wb_load`=1; next state is IDLE. The held upstream instruction is not re-accepted.
- **Requests**: `dmem_read`/`dmem_write` are driven from state and latched fields only, and held stable until `dmem_resp`. They are never both high.
- **Byte enables and write data**:
  - Word ops: `dmem_byte_enable`=2'b11; `dmem_address` passed unmodified.
  - STB: byte_enable = addr[0] ? 2'b10 : 2'b01; wdata = {sr[7:0], sr[7:0]}.
- **Writeback value (`regfilemux_out`)**:
  - LDR/LDI: `dmem_rdata`.
  - LDB: ZEXT(addr[0] ? rdata[15:8] : rdata[7:0]).
  - JSR/JSRR/TRAP: `pc_in`.
  - Everything else: `alu_out_in`.
  - The TRAP vector fetch is not performed here.
- **`load_regfile_out`**: copy of the latched `load_regfile_in`. Stores carry whatever decode supplied.
- **`stall_out`** (combinational): (IDLE ∧ `in_valid` ∧ memory op) ∨ ACC1 ∨ ACC2.
- **Spurious `dmem_resp`** in IDLE or RESULT: ignored.

## Timing
- **Reset**: state=IDLE. Every output is 0 (`dmem_read`, `dmem_write`, `dmem_address`, `dmem_wdata`, `dmem_byte_enable`, `stall_out`, `wb_load`, `dest_out`, `regfilemux_out`, `load_regfile_out`).
- **Reset mid-transaction**: the request drops the cycle after reset is sampled; a later `dmem_resp` is ignored.
- **Result registers**: `dest_out`, `regfilemux_out`, `load_regfile_out`, `wb_load` are registered.
- **Pass-through latency**: accepted at edge N, `wb_load`=1 in cycle N+1. Throughput is one instruction per cycle, with no stall.
- **Single-access op**:
  - Accept at edge N; request asserted from cycle N+1.
  - `dmem_resp` sampled at edge M; `wb_load`=1 and `stall_out`=0 in cycle M+1.
  - The next instruction is accepted no earlier than edge M+2.
  - Minimum 3 cycles per memory op.
- **Indirect op**: ACC2's request begins the cycle after the first `dmem_resp`. Minimum 4 cycles.
- **`wb_load`**: exactly one cycle per instruction; never high in two consecutive cycles for the same instruction.
- **Idle**: `in_valid`=0 in IDLE gives `wb_load`=0 next cycle; the result outputs hold their last values.

## Configuration
- `MEM_STAGE_INDIRECT_EN` defined: ACC2 exists; LDI/STI perform two accesses as above.
- Undefined:
  - ACC2 is removed.
  - LDI behaves exactly as LDR.
  - STI behaves exactly as STR: a single access at `alu_out_in`.
  - All other timing is unchanged.

## Test plan
- **Reset, then ADD**: ADD, dest=R3, alu_out=0x1234, load_regfile=1 → next cycle `wb_load`=1, dest_out=3, regfilemux_out=0x1234, `stall_out` never high.
- **LDR with delayed response**: LDR addr 0x2000; `dmem_resp` delayed 3 cycles, rdata 0xBEEF → `dmem_read`=1, address 0x2000, byte_enable 11 held throughout; `stall_out` high until the resp cycle; next cycle `wb_load`=1, regfilemux_out=0xBEEF.
- **Byte ops**:
  - STB addr 0x3001, sr=0x00A5 → `dmem_write`, byte_enable 10, wdata 0xA5A5.
  - LDB addr 0x3001, rdata 0x80FF → regfilemux_out=0x0080.
- **LDI with macro defined**: LDI addr 0x4000; first rdata 0x5000, second rdata 0x7777 → second read at 0x5000; `wb_load` once; regfilemux_out=0x7777.
- **STI with macro defined**: STI addr 0x4000 → read 0x4000, then write sr_data at the returned pointer.
- **Macro undefined**: LDI addr 0x4000, rdata 0x5000 → single read at 0x4000; regfilemux_out=0x5000.
- **Reset during ACC1**:
  - Assert reset while `dmem_read`=1 → `dmem_read`=0 and all outputs 0 next cycle.
  - A `dmem_resp` pulse 2 cycles later → no `wb_load`.
  - A following ADD completes normally.
